// File: rtl/rsa_pkg.sv
// Shared RSA definitions: default operand width and the decryptor FSM encoding,
// also used by the key-generation stage.
package rsa_pkg;

    localparam int INPUTSIZE_DEF = 24;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD   = 3'd1,
        MUL    = 3'd2,
        RED    = 3'd3,
        FINISH = 3'd4
    } state_t;

endpackage

// File: rtl/modexp_decrypt_if.sv
// Bundle of the decryptor request/response signals. start is sampled only while
// the block is idle; done is a single-cycle pulse that carries m and err.
interface modexp_decrypt_if #(
    parameter int W = 24
) (
    input logic clk
);

    logic         start;
    logic [W-1:0] c;
    logic [W-1:0] d;
    logic [W-1:0] n;
    logic [W-1:0] m;
    logic         busy;
    logic         done;
    logic         err;

    modport master (input clk, output start, c, d, n, input m, busy, done, err);
    modport slave  (input clk, input start, c, d, n, output m, busy, done, err);

endinterface

// File: rtl/mod_mul.sv
// Registered 2W-bit product of a and b, presented reduced modulo n.
// The product is captured when en is high; the reduction is combinational.
module mod_mul #(
    parameter int W = 24
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic [W-1:0] n,
    output logic [W-1:0] r
);

    logic [2*W-1:0] prod_q;
    logic [2*W-1:0] prod_d;
    logic [W-1:0]   n_div;

    always_comb begin
        prod_d = prod_q;
        if (en) begin
            prod_d = {{W{1'b0}}, a} * {{W{1'b0}}, b};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            prod_q <= '0;
        end else begin
            prod_q <= prod_d;
        end
    end

    // The owner never consumes r while n is zero; the substitute divisor keeps it defined.
    assign n_div = (n == '0) ? W'(1) : n;
    assign r     = W'(prod_q % {{W{1'b0}}, n_div});

endmodule

// File: rtl/modexp_decrypt.sv
// RSA decryption m = c^d mod n by right-to-left square-and-multiply.
// Optional macro MODEXP_EARLY_EXIT_EN finishes as soon as the remaining exponent is zero.
module modexp_decrypt
    import rsa_pkg::*;
#(
    parameter int INPUTSIZE = INPUTSIZE_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [INPUTSIZE-1:0] c,
    input  logic [INPUTSIZE-1:0] d,
    input  logic [INPUTSIZE-1:0] n,
    output logic [INPUTSIZE-1:0] m,
    output logic                 busy,
    output logic                 done,
    output logic                 err,
    output state_t               dbg_state
);

    localparam int             CW       = $clog2(INPUTSIZE + 1);
    localparam logic [CW-1:0]  LAST_BIT = CW'(INPUTSIZE - 1);

    state_t                 state_q, state_d;
    logic [INPUTSIZE-1:0]   c_q, c_d;
    logic [INPUTSIZE-1:0]   d_q, d_d;
    logic [INPUTSIZE-1:0]   n_q, n_d;
    logic [INPUTSIZE-1:0]   base_q, base_d;
    logic [INPUTSIZE-1:0]   result_q, result_d;
    logic [INPUTSIZE-1:0]   exp_q, exp_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic [INPUTSIZE-1:0]   m_q, m_d;
    logic                   err_q, err_d;

    logic                   mul_en_res;
    logic                   mul_en_base;
    logic [INPUTSIZE-1:0]   res_red;
    logic [INPUTSIZE-1:0]   base_red;
    logic [INPUTSIZE-1:0]   n_div;
    logic [INPUTSIZE-1:0]   exp_next;
    logic [INPUTSIZE-1:0]   res_next;
    logic                   finish_now;

    mod_mul #(.W(INPUTSIZE)) u_mul_res (
        .clk (clk),
        .rst (rst),
        .en  (mul_en_res),
        .a   (result_q),
        .b   (base_q),
        .n   (n_q),
        .r   (res_red)
    );

    mod_mul #(.W(INPUTSIZE)) u_mul_base (
        .clk (clk),
        .rst (rst),
        .en  (mul_en_base),
        .a   (base_q),
        .b   (base_q),
        .n   (n_q),
        .r   (base_red)
    );

    assign n_div    = (n_q == '0) ? INPUTSIZE'(1) : n_q;
    assign exp_next = exp_q >> 1;

    always_comb begin
        state_d     = state_q;
        c_d         = c_q;
        d_d         = d_q;
        n_d         = n_q;
        base_d      = base_q;
        result_d    = result_q;
        exp_d       = exp_q;
        cnt_d       = cnt_q;
        m_d         = m_q;
        err_d       = err_q;
        mul_en_res  = 1'b0;
        mul_en_base = 1'b0;
        res_next    = result_q;
        finish_now  = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    c_d     = c;
                    d_d     = d;
                    n_d     = n;
                    err_d   = 1'b0;
                    state_d = LOAD;
                end
            end
            LOAD: begin
                // A zero modulus has no meaningful result; report it straight away.
                if (n_q == '0) begin
                    m_d     = '0;
                    err_d   = 1'b1;
                    state_d = FINISH;
                end else begin
                    base_d   = c_q % n_div;
                    result_d = (n_q == INPUTSIZE'(1)) ? '0 : INPUTSIZE'(1);
                    exp_d    = d_q;
                    cnt_d    = '0;
                    state_d  = MUL;
                end
            end
            MUL: begin
`ifdef MODEXP_EARLY_EXIT_EN
                if (exp_q == '0) begin
                    m_d     = result_q;
                    state_d = FINISH;
                end else begin
                    mul_en_res  = exp_q[0];
                    mul_en_base = 1'b1;
                    state_d     = RED;
                end
`else
                mul_en_res  = exp_q[0];
                mul_en_base = 1'b1;
                state_d     = RED;
`endif
            end
            RED: begin
                res_next   = exp_q[0] ? res_red : result_q;
                base_d     = base_red;
                result_d   = res_next;
                exp_d      = exp_next;
                cnt_d      = cnt_q + CW'(1);
                finish_now = (cnt_q == LAST_BIT);
`ifdef MODEXP_EARLY_EXIT_EN
                finish_now = finish_now || (exp_next == '0);
`endif
                if (finish_now) begin
                    m_d     = res_next;
                    state_d = FINISH;
                end else begin
                    state_d = MUL;
                end
            end
            FINISH: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            c_q      <= '0;
            d_q      <= '0;
            n_q      <= '0;
            base_q   <= '0;
            result_q <= '0;
            exp_q    <= '0;
            cnt_q    <= '0;
            m_q      <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            c_q      <= c_d;
            d_q      <= d_d;
            n_q      <= n_d;
            base_q   <= base_d;
            result_q <= result_d;
            exp_q    <= exp_d;
            cnt_q    <= cnt_d;
            m_q      <= m_d;
            err_q    <= err_d;
        end
    end

    assign m         = m_q;
    assign busy      = (state_q != IDLE);
    assign done      = (state_q == FINISH);
    assign err       = err_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_modexp_decrypt.sv
// Self-checking bench for modexp_decrypt: directed vectors plus randomized operands
// against a left-to-right modular exponentiation reference. Honours MODEXP_EARLY_EXIT_EN.
module tb_modexp_decrypt;
    import rsa_pkg::*;

    localparam int W = 24;

    logic   clk;
    logic   rst;
    state_t dbg_state;
    int     checks;
    int     failures;
    logic [W-1:0] exp_q[$];

    modexp_decrypt_if #(.W(W)) bus (.clk(clk));

    modexp_decrypt #(.INPUTSIZE(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (bus.start),
        .c         (bus.c),
        .d         (bus.d),
        .n         (bus.n),
        .m         (bus.m),
        .busy      (bus.busy),
        .done      (bus.done),
        .err       (bus.err),
        .dbg_state (dbg_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
        end
    endtask

    // Left-to-right exponentiation, plain 64-bit arithmetic.
    function automatic logic [W-1:0] ref_modexp(input logic [W-1:0] c_v, d_v, n_v);
        longint unsigned r;
        longint unsigned b;
        if (n_v == 0) return '0;
        b = longint'(c_v) % longint'(n_v);
        r = 1 % longint'(n_v);
        for (int i = W - 1; i >= 0; i--) begin
            r = (r * r) % longint'(n_v);
            if (d_v[i]) r = (r * b) % longint'(n_v);
        end
        return W'(r);
    endfunction

    function automatic int ref_latency(input logic [W-1:0] d_v, n_v);
        if (n_v == 0) return 1;
`ifdef MODEXP_EARLY_EXIT_EN
        begin
            int bl;
            bl = 0;
            for (int i = 0; i < W; i++) if (d_v[i]) bl = i + 1;
            return (bl == 0) ? 2 : 1 + 2 * bl;
        end
`else
        if (d_v == d_v) return 2 * W + 1;
        return 0;
`endif
    endfunction

    // mode 1: pulse start and scramble inputs around edge 10 of the operation.
    task automatic run_op(input logic [W-1:0] c_v, d_v, n_v, input logic [W-1:0] m_exp,
                          input logic err_exp, input int mode);
        int          lat;
        int          edge_n;
        logic        got_done;
        logic [W-1:0] m_ref;
        lat = ref_latency(d_v, n_v);
        exp_q.push_back(m_exp);
        @(negedge clk);
        rst       = 1'b0;
        bus.start = 1'b1;
        bus.c     = c_v;
        bus.d     = d_v;
        bus.n     = n_v;
        @(posedge clk);
        #1;
        check("busy_edge0", bus.busy, 1);
        check("err_clear_edge0", bus.err, 0);
        edge_n   = 0;
        got_done = 1'b0;
        @(negedge clk);
        bus.start = 1'b0;
        while (!got_done && edge_n < 200) begin
            @(posedge clk);
            edge_n++;
            #1;
            if (bus.done) got_done = 1'b1;
            if (mode == 1 && edge_n == 9) begin
                bus.start = 1'b1;
                bus.c     = W'($urandom);
                bus.d     = W'($urandom);
                bus.n     = W'($urandom);
            end
            if (mode == 1 && edge_n == 10) bus.start = 1'b0;
        end
        m_ref = exp_q.pop_front();
        check("done_seen", got_done, 1);
        if (got_done) begin
            check("done_edge", edge_n, lat);
            check("m_value", bus.m, m_ref);
            check("err_value", bus.err, err_exp);
            check("busy_at_done", bus.busy, 1);
        end
        @(posedge clk);
        #1;
        check("done_one_cycle", bus.done, 0);
        check("busy_idle", bus.busy, 0);
        @(posedge clk);
        #1;
        check("no_second_done", bus.done, 0);
        check("m_held", bus.m, m_ref);
    endtask

    initial begin
        logic [31:0] cv;
        logic [31:0] dv;
        logic [31:0] nv;
        checks    = 0;
        failures  = 0;
        rst       = 1'b1;
        bus.start = 1'b0;
        bus.c     = '0;
        bus.d     = '0;
        bus.n     = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_m", bus.m, 0);
        check("reset_busy", bus.busy, 0);
        check("reset_done", bus.done, 0);
        check("reset_err", bus.err, 0);
        check("reset_state", dbg_state, IDLE);

        run_op(24'd2790, 24'd2753, 24'd3233, 24'd65, 1'b0, 0);
        run_op(24'd4, 24'd13, 24'd497, 24'd445, 1'b0, 0);
        run_op(24'd6023, 24'd2753, 24'd3233, 24'd65, 1'b0, 0);
        run_op(24'd5, 24'd0, 24'd7, 24'd1, 1'b0, 0);
        run_op(24'd5, 24'd13, 24'd1, 24'd0, 1'b0, 0);
        run_op(24'd5, 24'd13, 24'd0, 24'd0, 1'b1, 0);
        run_op(24'd2790, 24'd2753, 24'd3233, 24'd65, 1'b0, 1);

        // Reset in the middle of an operation.
        @(negedge clk);
        bus.start = 1'b1;
        bus.c     = 24'd2790;
        bus.d     = 24'd2753;
        bus.n     = 24'd3233;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        repeat (19) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("midrst_m", bus.m, 0);
        check("midrst_busy", bus.busy, 0);
        check("midrst_done", bus.done, 0);
        check("midrst_err", bus.err, 0);
        run_op(24'd2790, 24'd2753, 24'd3233, 24'd65, 1'b0, 0);

        for (int i = 0; i < 8; i++) begin
            cv = $urandom;
            dv = $urandom;
            nv = $urandom_range(2, 32'h00FF_FFFF);
            if (i < 2) nv = $urandom_range(2, 255);
            run_op(cv[W-1:0], dv[W-1:0], nv[W-1:0],
                   ref_modexp(cv[W-1:0], dv[W-1:0], nv[W-1:0]), 1'b0, 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/modexp_decrypt.md
MODEXP_DECRYPT -- requirements
Module: modexp_decrypt

Interface
REQ-001 SHALL have parameter INPUTSIZE, default 24, operand and key width in bits.
REQ-002 SHALL have port clk, input, 1, the single clock; all logic on rising edge.
REQ-003 SHALL have port rst, input, 1, reset; synchronous and active-high.
REQ-004 SHALL have port start, input, 1, request to begin one decryption.
REQ-005 SHALL have port c, input, INPUTSIZE, ciphertext.
REQ-006 SHALL have port d, input, INPUTSIZE, private exponent from the key-generation stage.
REQ-007 SHALL have port n, input, INPUTSIZE, modulus.
REQ-008 SHALL have port m, output, INPUTSIZE, plaintext c^d mod n; registered.
REQ-009 SHALL have port busy, output, 1, high while an operation is in progress.
REQ-010 SHALL have port done, output, 1, one-cycle completion pulse.
REQ-011 SHALL have port err, output, 1, set with done when n == 0.

Function
REQ-012 SHALL implement states IDLE, LOAD, MUL, RED, FINISH.
REQ-013 SHALL sample start only in IDLE; start in any other state SHALL be ignored.
REQ-014 SHALL latch c, d and n on the edge that samples start; later input changes SHALL NOT affect the operation in flight.
REQ-015 SHALL, in LOAD, set base = c mod n, result = 1 mod n, exp = d and bit counter = 0.
REQ-016 SHALL use right-to-left square-and-multiply.
REQ-017 SHALL, in MUL, form 2*INPUTSIZE-bit products result*base (only if exp[0] = 1) and base*base.
REQ-018 SHALL, in RED, reduce both products mod n, shift exp right by 1 and increment the counter.
REQ-019 SHALL return from RED to MUL until INPUTSIZE bits are processed, then go to FINISH.
REQ-020 SHALL, with the edge that samples start counted as edge 0, assert done and update m on edge 2*INPUTSIZE+1 (edge 49 at INPUTSIZE=24).
REQ-021 SHALL drive done high for exactly one cycle, then return to IDLE.
REQ-022 SHALL hold m stable from done until the next done.
REQ-023 SHALL drive busy high from edge 0 up to and including the cycle done is high; busy SHALL be low in IDLE.
REQ-024 SHALL, if n == 0, skip LOAD/MUL/RED and go to FINISH, then assert done and err with m = 0 on edge 1.
REQ-025 SHALL clear err on the next accepted start.
REQ-026 SHALL yield m = 0 when n == 1, and m = 1 mod n when d == 0.
REQ-027 SHALL reduce c >= n correctly through the LOAD reduction.
REQ-028 SHALL keep every intermediate value below n after each RED.

Reset
REQ-029 SHALL, when rst is high at a clock edge in any state, go to IDLE and clear m, busy, done, err, base, result, exp and counter to 0.
REQ-030 SHALL, when reset occurs mid-operation, abandon that operation without asserting done.
REQ-031 SHALL accept a start on the first edge after rst is deasserted.

Configuration
REQ-032 SHALL support macro MODEXP_EARLY_EXIT_EN.
REQ-033 SHALL, when MODEXP_EARLY_EXIT_EN is defined, go from RED to FINISH as soon as the remaining exp == 0; latency then depends on the bit length of d, and d == 0 completes on edge 2.
REQ-034 SHALL, when MODEXP_EARLY_EXIT_EN is not defined, use the fixed latency of REQ-020 for every n != 0, independent of d.

Structure
REQ-035 SHALL place the INPUTSIZE default and the state encoding in shared package rsa_pkg, used also by the key-generation stage.
REQ-036 SHALL implement the product-and-reduce datapath as one sub-module, mod_mul: 2*INPUTSIZE-bit multiply then modulo n.
REQ-037 SHALL instantiate mod_mul twice, once for result and once for base.

Verification
REQ-038 SHALL cover: c=2790, d=2753, n=3233 -> m=65; done on edge 49, err=0.
REQ-039 SHALL cover: c=4, d=13, n=497 -> m=445; then c=6023, d=2753, n=3233 -> m=65 (c >= n case).
REQ-040 SHALL cover: d=0, c=5, n=7 -> m=1; n=1 -> m=0; n=0 -> done and err on edge 1, m=0.
REQ-041 SHALL cover: start pulsed again at edge 10 of a busy operation, and inputs changed mid-flight -> ignored; first result unchanged, one done only.
REQ-042 SHALL cover: rst at edge 20 of an operation -> no done, all outputs 0; next start with c=2790, d=2753, n=3233 -> m=65.
REQ-043 SHALL cover, with MODEXP_EARLY_EXIT_EN defined: d=13 (4 bits), c=4, n=497 -> m=445, done on edge 9.
